// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-set instruction cache.
//
// Lookups are combinational in IDLE. A miss latches the fetch address and
// moves to FILL, which holds a single memory read until iwait drops. Flush
// clears every valid bit. A flush on the same edge that a fill completes
// discards the fill write.
//
// Optional feature (macro ICACHE_STATS_EN): adds saturating hit_count and
// miss_count outputs.
//
// Parameters:
//   SETS   number of sets (power of two, 2..64)
//   TAG_W  tag width, 32 - 2 - log2(SETS)
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   imemREN         datapath read request
//   imemaddr        datapath fetch address (bits [1:0] ignored)
//   ihit, imemload  hit strobe and instruction word (zero when no hit)
//   flush           invalidate all sets
//   iREN, iaddr     memory-side read request and word address
//   iwait, iload    memory busy flag and read data
//   hit_count, miss_count  (ICACHE_STATS_EN only) event counters
module icache_direct #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned TAG_W = 32 - 2 - $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IdxW = $clog2(SETS);

    typedef enum logic {StIdle, StFill} state_e;

    state_e            state_q, state_d;
    logic [29:0]       miss_addr_q, miss_addr_d;   // word address of the pending fill
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IdxW-1:0]   req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IdxW-1:0]   fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              fill_we;
    logic              miss_start;

    assign req_idx  = imemaddr[2 +: IdxW];
    assign req_tag  = imemaddr[31 -: TAG_W];
    assign fill_idx = miss_addr_q[IdxW-1:0];
    assign fill_tag = miss_addr_q[29 -: TAG_W];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        iREN        = 1'b0;
        iaddr       = '0;
        fill_we     = 1'b0;
        miss_start  = 1'b0;
        case (state_q)
            StIdle: begin
                // Flush wins over a lookup in the same cycle.
                ihit = imemREN && lookup_hit && !flush;
                if (imemREN && !ihit) begin
                    miss_addr_d = imemaddr[31:2];
                    state_d     = StFill;
                    miss_start  = 1'b1;
                end
            end
            StFill: begin
                iREN  = 1'b1;
                iaddr = {miss_addr_q, 2'b00};
                if (!iwait) begin
                    fill_we = !flush;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imemload = ihit ? data_q[req_idx] : '0;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (fill_we) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data storage needs no reset: entries are qualified by valid_q, and
    // reset forces StIdle so no write can land while RST is high.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_miss_start;
    assign unused_miss_start = miss_start;
`endif

    // Byte-offset bits never take part in a lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct #(.SETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] hit_q [$];   // expected imemload per ihit cycle
    logic [31:0] fill_q [$];  // expected iaddr per fill
    int          wait_target = 0;
    logic [31:0] cur_fill = '0;
    logic        iren_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: mem_word = 32'h8C22_0004;
            32'h0000_0044: mem_word = 32'h2442_0001;
            32'h0000_0080: mem_word = 32'hAC43_0008;
            32'h0000_0100: mem_word = 32'h1000_FFFF;
            32'h0000_0200: mem_word = 32'h3C01_1234;
            32'h0000_0300: mem_word = 32'h0085_1020;
            default:       mem_word = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Memory model: iwait held high for wait_target cycles of each fill.
    initial begin
        int busy;
        busy  = 0;
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (iREN) begin
                if (busy < wait_target) begin
                    iwait = 1'b1;
                    busy++;
                end else begin
                    iwait = 1'b0;
                    iload = mem_word(iaddr);
                end
            end else begin
                iwait = 1'b1;
                busy  = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a hit or a fill.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (ihit) begin
                    if (hit_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_hit: imemaddr %h imemload %h, no hit expected",
                                 imemaddr, imemload);
                    end else begin
                        check("hit_data", imemload, hit_q.pop_front());
                    end
                end
                if (iREN && !iren_prev) begin
                    if (fill_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_fill: iaddr %h, no fill expected", iaddr);
                    end else begin
                        cur_fill = fill_q.pop_front();
                        check("fill_addr", iaddr, cur_fill);
                    end
                end else if (iREN) begin
                    check("fill_addr_stable", iaddr, cur_fill);
                end
            end
            iren_prev = iREN;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for the first ihit; counts iREN cycles on the way.
    task automatic wait_hit(input logic [31:0] addr, output int iren_cycles);
        bit got;
        got         = 1'b0;
        iren_cycles = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if (iREN) iren_cycles++;
            if (ihit) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL hit_timeout: addr %h got no ihit, required one within 60 cycles", addr);
        end
    endtask

    // Request addr, hold it for n_hits hit cycles, then drop the request.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit miss,
                         input int n_hits, output int iren_cycles);
        if (miss) fill_q.push_back(addr & 32'hFFFF_FFFC);
        for (int i = 0; i < n_hits; i++) hit_q.push_back(data);
        imemaddr = addr;
        imemREN  = 1'b1;
        wait_hit(addr, iren_cycles);
        repeat (n_hits) @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    initial begin
        int c;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        #1;
        check("rst_ihit", 32'(ihit), 0);
        check("rst_iren", 32'(iREN), 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_imemload", imemload, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("idle_iren", 32'(iREN), 0);
        check("idle_iaddr", iaddr, 0);
        @(posedge CLK);
        #1;

        // Cold miss: 3 busy cycles -> 4 cycles of iREN, then a hit.
        wait_target = 3;
        fetch(32'h40, 32'h8C22_0004, 1'b1, 1, c);
        check("cold_iren_cycles", 32'(c), 4);

        // Conflict on index 0; index 1 undisturbed.
        wait_target = 1;
        fetch(32'h44, 32'h2442_0001, 1'b1, 1, c);
        fetch(32'h40, 32'h8C22_0004, 1'b0, 2, c);
        check("hit_no_fill", 32'(c), 0);
        fetch(32'h80, 32'hAC43_0008, 1'b1, 1, c);
        fetch(32'h40, 32'h8C22_0004, 1'b1, 1, c);
        fetch(32'h44, 32'h2442_0001, 1'b0, 1, c);
        check("other_set_kept", 32'(c), 0);

        // Redirect mid-fill: fill for 0x100 completes, then 0x200 fills.
        wait_target = 3;
        fill_q.push_back(32'h100);
        fill_q.push_back(32'h200);
        hit_q.push_back(32'h3C01_1234);
        imemaddr = 32'h100;
        imemREN  = 1'b1;
        @(posedge CLK);
        #1;
        imemaddr = 32'h200;
        @(negedge CLK);
        check("redirect_iaddr", iaddr, 32'h100);
        wait_hit(32'h200, c);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        // Flush pulse while idle.
        wait_target = 1;
        fetch(32'h40, 32'h8C22_0004, 1'b1, 1, c);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        fetch(32'h40, 32'h8C22_0004, 1'b1, 1, c);
        fetch(32'h44, 32'h2442_0001, 1'b1, 1, c);

        // Flush alongside a request to a valid line forces a miss.
        fill_q.push_back(32'h40);
        hit_q.push_back(32'h8C22_0004);
        imemaddr = 32'h40;
        imemREN  = 1'b1;
        flush    = 1'b1;
        @(negedge CLK);
        check("flush_forces_miss", 32'(ihit), 0);
        @(posedge CLK);
        #1;
        flush = 1'b0;
        wait_hit(32'h40, c);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        // Flush on the completing edge of a fill discards the write.
        wait_target = 0;
        fill_q.push_back(32'h80);
        fill_q.push_back(32'h80);
        hit_q.push_back(32'hAC43_0008);
        imemaddr = 32'h80;
        imemREN  = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        @(negedge CLK);
        check("flush_discards_fill", 32'(ihit), 0);
        wait_hit(32'h80, c);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        // Asynchronous reset in the middle of a fill.
        wait_target = 5;
        fill_q.push_back(32'h300);
        imemaddr = 32'h300;
        imemREN  = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("async_rst_iren", 32'(iREN), 0);
        check("async_rst_iaddr", iaddr, 0);
        check("async_rst_ihit", 32'(ihit), 0);
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_target = 1;
        fetch(32'h300, 32'h0085_1020, 1'b1, 5, c);
`ifdef ICACHE_STATS_EN
        check("miss_count", miss_count, 1);
        check("hit_count", hit_count, 5);
`endif
        fetch(32'h40, 32'h8C22_0004, 1'b1, 1, c);

        @(negedge CLK);
        check("hit_queue_drained", 32'(hit_q.size()), 0);
        check("fill_queue_drained", 32'(fill_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped one-word sets (power of two, 2..64).
REQ-002 SHALL have parameter TAG_W, default 32-2-log2(SETS), tag width derived from SETS.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 imemREN  input  1  datapath instruction read request.
REQ-006 imemaddr  input  32  datapath fetch address; bits[1:0] ignored.
REQ-007 ihit  output  1  instruction valid this cycle.
REQ-008 imemload  output  32  instruction word for imemaddr when ihit=1.
REQ-009 flush  input  1  invalidate all sets.
REQ-010 iREN  output  1  memory-side read request.
REQ-011 iaddr  output  32  memory-side word address, bits[1:0]=0.
REQ-012 iwait  input  1  memory busy; iwait=0 while iREN=1 means iload valid.
REQ-013 iload  input  32  memory read data.

Function
REQ-014 Address split SHALL be: index = imemaddr[2+log2(SETS)-1:2], tag = imemaddr[31:2+log2(SETS)].
REQ-015 Each set SHALL hold a valid bit, a TAG_W tag, and a 32-bit word.
REQ-016 FSM SHALL have two states: IDLE and FILL.
REQ-017 In IDLE, ihit SHALL be combinational: imemREN & valid[index] & tag match; imemload = stored word; zero-cycle hit latency.
REQ-018 In IDLE with imemREN=1 and no hit, the block SHALL register imemaddr into a miss address and enter FILL next cycle; ihit=0 that cycle.
REQ-019 In FILL, iREN SHALL be 1, iaddr SHALL be the registered miss address, and ihit SHALL be 0.
REQ-020 In FILL, when iwait=0, the set SHALL load iload, tag, and valid=1, and the FSM SHALL return to IDLE on that edge; the refilled word is served as a hit the next cycle at the earliest (two-cycle minimum miss penalty, excluding iwait).
REQ-021 A change of imemaddr or a drop of imemREN during FILL SHALL NOT abort or retarget the fill; after completion, IDLE re-evaluates the current request.
REQ-022 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-023 flush=1 in IDLE SHALL clear all valid bits on that edge and force ihit=0 that cycle.
REQ-024 flush=1 in FILL SHALL clear all valid bits on that edge; if iwait=0 on the same edge, the fill write is discarded (set stays invalid) and the FSM returns to IDLE.
REQ-025 Two addresses mapping to the same index SHALL evict each other; no other set is disturbed.

Reset
REQ-026 RST=1 SHALL asynchronously clear all valid bits, set the FSM to IDLE, and clear the miss address.
REQ-027 During and after reset until the next request: ihit=0, iREN=0, iaddr=0, imemload=0.
REQ-028 RST asserted during FILL SHALL abandon the fill; no set is written.

Configuration
REQ-029 With macro ICACHE_STATS_EN defined, the block SHALL add outputs hit_count[31:0] and miss_count[31:0]. The counters increment once per cycle with ihit=1 and once per IDLE->FILL transition, respectively. Both saturate at 0xFFFFFFFF and are cleared by RST.
REQ-030 Without ICACHE_STATS_EN, these ports and counters SHALL NOT exist, and the remaining behaviour SHALL be identical.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x00000040, memory returns iload=0x8C220004 after iwait=1 for 3 cycles -> iREN=1 and iaddr=0x40 for 4 cycles, then ihit=1 and imemload=0x8C220004 in the following cycle.
REQ-032 Conflict: with SETS=16, fill 0x00000040, then request 0x00000080 (same index 0) -> miss and refill; a subsequent request to 0x00000040 misses again.
REQ-033 Redirect mid-fill: imemaddr changes from 0x100 to 0x200 while iwait=1 -> iaddr stays 0x100 until iwait=0; then a second fill is issued for 0x200.
REQ-034 Flush: after 0x40 is valid, pulse flush for 1 cycle -> the next request to 0x40 gives ihit=0 and enters FILL; flush coinciding with iwait=0 leaves the set invalid.
REQ-035 Async reset mid-fill: assert RST between edges during FILL -> iREN drops immediately, and the request after release misses.
REQ-036 With ICACHE_STATS_EN: 1 miss then 5 hit cycles -> miss_count=1, hit_count=5.
